// File: rtl/lsu_pkg.sv
// lsu_pkg: size codes, FSM encoding and alignment rule shared by the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR,
    RESP
  } state_e;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
    return size == SZ_ILL || (size == SZ_HALF && lane[0]) || (size == SZ_WORD && lane != 2'b00);
  endfunction

endpackage

// File: rtl/load_store_unit_lane.sv
// load_store_unit_lane: little-endian lane merge for sub-word stores and lane extraction with extension for loads.
module load_store_unit_lane
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  logic [1:0]  size_i,
  input  logic [31:0] wdata_i,
  input  logic        uns_i,
  output logic [31:0] merged_o,
  output logic [31:0] rdata_o
);

  logic [4:0]  sh;
  logic [31:0] mask;
  logic [15:0] ext;

  always_comb begin
    sh = size_i == SZ_BYTE ? {lane_i, 3'b000} : size_i == SZ_HALF ? {lane_i[1], 4'b0000} : 5'd0;
    mask = size_i == SZ_BYTE ? 32'h0000_00ff << sh : size_i == SZ_HALF ? 32'h0000_ffff << sh : 32'hffff_ffff;
    merged_o = (word_i & ~mask) | ((wdata_i << sh) & mask);
    ext = 16'(word_i >> sh);
    rdata_o = size_i == SZ_BYTE ? {{24{~uns_i & ext[7]}}, ext[7:0]} :
              size_i == SZ_HALF ? {{16{~uns_i & ext[15]}}, ext} : word_i;
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: sequential byte/half/word load-store controller with read-modify-write in front of a word RAM.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              ram_readWrite,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_dataIN,
  input  logic [DATA_W-1:0] ram_dataOUT
);

  state_e              state_q, state_d;
  logic                write_q, uns_q, accept;
  logic [1:0]          size_q, lane_q;
  logic [DATA_W-1:0]   wdata_q, merged, ld_data;
  logic                resp_valid_q, resp_err_q, ram_rw_q;
  logic [DATA_W-1:0]   resp_rdata_q, ram_din_q;
  logic [ADDR_W-1:0]   ram_addr_q;

  load_store_unit_lane u_lane (
    .word_i  (ram_dataOUT),
    .lane_i  (lane_q),
    .size_i  (size_q),
    .wdata_i (wdata_q),
    .uns_i   (uns_q),
    .merged_o(merged),
    .rdata_o (ld_data)
  );

  assign accept = state_q == IDLE && req_valid;

  always_comb begin
    state_d = state_q == IDLE    ? (!req_valid ? IDLE :
                                    misaligned(req_size, req_addr[1:0]) ? RESP :
                                    (req_write && req_size == SZ_WORD) ? WR : RD_ADDR) :
              state_q == RD_ADDR ? RD_DATA :
              state_q == RD_DATA ? (write_q ? WR : RESP) :
              state_q == WR      ? RESP : IDLE;
  end

  // Outputs are registered from the next state so each one is valid for exactly the state it belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      write_q      <= 1'b0;
      uns_q        <= 1'b0;
      size_q       <= 2'b00;
      lane_q       <= 2'b00;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      ram_rw_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_din_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        write_q <= req_write;
        uns_q   <= req_unsigned;
        size_q  <= req_size;
        lane_q  <= req_addr[1:0];
        wdata_q <= req_wdata;
      end
      ram_addr_q   <= state_d == IDLE ? '0 : accept ? req_addr[ADDR_W+1:2] : ram_addr_q;
      ram_rw_q     <= state_d == WR;
      ram_din_q    <= state_d != WR ? '0 : accept ? req_wdata : merged;
      resp_valid_q <= state_d == RESP;
      resp_err_q   <= state_d == RESP && accept;
      resp_rdata_q <= (state_q == RD_DATA && !write_q) ? ld_data : '0;
    end
  end

  assign req_ready     = state_q == IDLE && rst_n;
  assign resp_valid    = resp_valid_q;
  assign resp_err      = resp_err_q;
  assign resp_rdata    = resp_rdata_q;
  assign ram_readWrite = ram_rw_q;
  assign ram_address   = ram_addr_q;
  assign ram_dataIN    = ram_din_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: random and directed requests checked against a byte-level memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_write = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [6:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid, resp_err, ram_readWrite;
  logic [31:0] resp_rdata, ram_dataIN, ram_dataOUT;
  logic [4:0]  ram_address;

  logic [31:0] mem [32];
  logic [31:0] ref_mem [32];
  int          n_chk = 0, n_err = 0, wr_cnt = 0;
  logic [4:0]  last_wa;
  logic [31:0] last_wd;

  load_store_unit dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_err(resp_err), .resp_rdata(resp_rdata), .ram_readWrite(ram_readWrite),
    .ram_address(ram_address), .ram_dataIN(ram_dataIN), .ram_dataOUT(ram_dataOUT)
  );

  always #5 clk = ~clk;

  assign ram_dataOUT = mem[ram_address];

  always @(posedge clk) begin
    if (ram_readWrite) begin
      mem[ram_address] <= ram_dataIN;
      wr_cnt  <= wr_cnt + 1;
      last_wa <= ram_address;
      last_wd <= ram_dataIN;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic rand_drive();
    req_valid    = 1'b1;
    req_write    = 1'($urandom);
    req_size     = 2'($urandom);
    req_unsigned = 1'($urandom);
    req_addr     = 7'($urandom);
    req_wdata    = $urandom;
  endtask

  task automatic lsu_req(input logic w, input logic [1:0] sz, input logic u,
                         input logic [6:0] a, input logic [31:0] wd, input logic junk);
    logic        mis, saw_ready;
    int          nb, ln, lat, base, exp_lat, n;
    logic [31:0] word, nw, exp_rd;
    mis = sz == 2'd3 || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
    nb  = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
    ln  = int'(a[1:0]);
    word = ref_mem[a[6:2]];
    nw = word;
    exp_rd = '0;
    if (!mis)
      for (int k = 0; k < nb; k++) begin
        exp_rd[8*k +: 8]  = word[8*(ln+k) +: 8];
        nw[8*(ln+k) +: 8] = wd[8*k +: 8];
      end
    if (!mis && !u && nb < 4 && exp_rd[8*nb-1])
      for (int k = nb; k < 4; k++) exp_rd[8*k +: 8] = 8'hff;
    if (mis || w) exp_rd = '0;
    exp_lat = mis ? 1 : w ? (sz == 2'd2 ? 2 : 4) : 3;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check("ready_timeout", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = wd;
    base = wr_cnt;
    @(posedge clk);
    #1;
    if (junk) rand_drive(); else req_valid = 1'b0;
    lat = 0;
    saw_ready = 1'b0;
    while (lat < 12) begin
      @(negedge clk);
      lat++;
      if (resp_valid) break;
      if (req_ready) saw_ready = 1'b1;
      if (junk) rand_drive();
    end
    check("latency", lat, exp_lat);
    check("resp_err", {31'd0, resp_err}, {31'd0, mis});
    check("resp_rdata", resp_rdata, exp_rd);
    check("busy_not_ready", {31'd0, saw_ready}, 32'd0);
    check("ram_addr_hold", {27'd0, ram_address}, {27'd0, a[6:2]});
    check("wr_count", wr_cnt - base, (!mis && w) ? 32'd1 : 32'd0);
    if (!mis && w) begin
      check("wr_addr", {27'd0, last_wa}, {27'd0, a[6:2]});
      check("wr_data", last_wd, nw);
      ref_mem[a[6:2]] = nw;
    end
    @(negedge clk);
    check("resp_pulse", {31'd0, resp_valid}, 32'd0);
    check("ready_idle", {31'd0, req_ready}, 32'd1);
    check("ram_addr_idle", {27'd0, ram_address}, 32'd0);
    req_valid = 1'b0;
  endtask

  initial begin
    int bad, seen_resp, base;
    logic [1:0] sz;
    logic [6:0] a;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, req_ready}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready_hi", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_rw", {31'd0, ram_readWrite}, 32'd0);
    check("rst_addr", {27'd0, ram_address}, 32'd0);
    check("rst_din", ram_dataIN, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    for (int i = 0; i < 32; i++) lsu_req(1'b1, 2'd2, 1'b0, 7'(i * 4), $urandom, 1'b0);
    lsu_req(1'b1, 2'd2, 1'b0, 7'h54, 32'hdeadbeef, 1'b0);
    lsu_req(1'b0, 2'd2, 1'b0, 7'h54, 32'h0, 1'b0);
    check("deadbeef_model", ref_mem[21], 32'hdeadbeef);
    lsu_req(1'b1, 2'd2, 1'b0, 7'h74, 32'h11223344, 1'b0);
    lsu_req(1'b1, 2'd0, 1'b0, 7'h76, 32'h000000aa, 1'b0);
    check("rmw_model", ref_mem[29], 32'h11aa3344);
    lsu_req(1'b0, 2'd2, 1'b0, 7'h74, 32'h0, 1'b0);
    lsu_req(1'b1, 2'd2, 1'b0, 7'h78, 32'h80f07f01, 1'b0);
    lsu_req(1'b0, 2'd0, 1'b0, 7'h7a, 32'h0, 1'b0);
    lsu_req(1'b0, 2'd0, 1'b1, 7'h7a, 32'h0, 1'b0);
    lsu_req(1'b0, 2'd1, 1'b0, 7'h7a, 32'h0, 1'b0);
    lsu_req(1'b0, 2'd2, 1'b0, 7'h7d, 32'h0, 1'b0);
    lsu_req(1'b1, 2'd1, 1'b0, 7'h79, 32'hffffffff, 1'b0);
    lsu_req(1'b0, 2'd3, 1'b0, 7'h78, 32'h0, 1'b0);
    lsu_req(1'b1, 2'd3, 1'b0, 7'h78, 32'h12345678, 1'b1);
    lsu_req(1'b1, 2'd1, 1'b0, 7'h32, 32'h0000beef, 1'b1);
    lsu_req(1'b0, 2'd1, 1'b0, 7'h32, 32'h0, 1'b1);
    lsu_req(1'b1, 2'd2, 1'b0, 7'h40, 32'hcafef00d, 1'b1);
    // Reset while the byte store sits in RD_DATA must not commit anything.
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 7'h76; req_wdata = 32'h55;
    base = wr_cnt;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_rw", {31'd0, ram_readWrite}, 32'd0);
    check("abort_addr", {27'd0, ram_address}, 32'd0);
    check("abort_din", ram_dataIN, 32'd0);
    check("abort_ready", {31'd0, req_ready}, 32'd0);
    seen_resp = 0;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid) seen_resp++;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid) seen_resp++;
    end
    check("abort_no_resp", seen_resp, 32'd0);
    check("abort_no_write", wr_cnt - base, 32'd0);
    lsu_req(1'b0, 2'd2, 1'b0, 7'h74, 32'h0, 1'b0);
    for (int i = 0; i < 150; i++) begin
      sz = 2'($urandom);
      a = 7'($urandom);
      if ($urandom_range(0, 3) != 0) a = sz == 2'd1 ? {a[6:1], 1'b0} : sz == 2'd2 ? {a[6:2], 2'b00} : a;
      lsu_req(1'($urandom), sz, 1'($urandom), a, $urandom, 1'($urandom));
    end
    bad = 0;
    for (int i = 0; i < 32; i++) if (mem[i] !== ref_mem[i]) bad++;
    check("mem_contents", bad, 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
